window_watch_controller: RTL and testbench
==========================================

Name: window_watch_controller

Overview:
- Configures and sequences NUM_WIN windowMonitor instances for address watchpoints.
- Loads start and end bounds, then commits each window through the monitors' shared DATA / LD_START / LD_END / ENABLE strobes.
- Masks the monitors' IN_WINDOW outputs with per-window arm bits, arbitrates simultaneous hits, and raises a single trap request to the CPU sequencer using a req/ack handshake.

Parameters:
- NUM_WIN, 4, number of windowMonitor instances controlled (1..8).
- IDX_W, 2, width of the window index (clog2 of NUM_WIN, minimum 1).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CFG_WR  in  1  one-cycle request to (re)configure a window; sampled only when CFG_BUSY=0.
- CFG_IDX  in  IDX_W  target window for CFG_WR.
- CFG_START  in  16  window start address (inclusive).
- CFG_END  in  16  window end address (inclusive).
- CFG_ARM  in  1  1 = arm the window after load; 0 = disarm without loading.
- CFG_BUSY  out  1  configuration sequence in progress.
- MON_DATA  out  16  shared DATA bus to all monitors.
- MON_LD_START  out  NUM_WIN  per-monitor LD_START strobe.
- MON_LD_END  out  NUM_WIN  per-monitor LD_END strobe.
- MON_ENABLE  out  NUM_WIN  per-monitor ENABLE strobe.
- MON_IN_WINDOW  in  NUM_WIN  IN_WINDOW outputs of the monitors.
- ADDR  in  16  address currently presented to the monitors; captured on a hit.
- ARMED  out  NUM_WIN  current arm mask.
- TRAP_REQ  out  1  watchpoint trap request.
- TRAP_IDX  out  IDX_W  index of the window that trapped.
- TRAP_ADDR  out  16  ADDR value at the trapping cycle.
- TRAP_ACK  in  1  CPU sequencer acknowledge.

Behaviour:
- Reset: all outputs are 0; config FSM is in IDLE; trap FSM is in T_IDLE; ARMED=0.

Config FSM: states IDLE, LD_S, LD_E, COMMIT.
- IDLE: CFG_WR=1 latches the request and sets CFG_BUSY=1 the next cycle.
  - CFG_ARM=1: go to LD_S.
  - CFG_ARM=0: clear ARMED[CFG_IDX] the next cycle, stay in IDLE; CFG_BUSY stays 0.
- LD_S: MON_DATA=start and MON_LD_START[idx]=1 for exactly one cycle. ARMED[idx] is cleared on entry, so the window cannot trap while it is half-loaded.
- LD_E: MON_DATA=end and MON_LD_END[idx]=1 for one cycle.
- COMMIT: MON_ENABLE[idx]=1 for one cycle, with MON_DATA held at end. ARMED[idx] sets at the end of this cycle. Then return to IDLE and CFG_BUSY returns to 0.
- Timing: an armed write completes 4 cycles after the CFG_WR edge.
- Strobe rules: at most one strobe bit is high in any cycle. MON_DATA is 0 whenever no strobe is active.
- CFG_WR while CFG_BUSY=1 is ignored and not queued.
- CFG_IDX >= NUM_WIN is ignored entirely.
- start > end is loaded as given; the resulting empty window is the monitor's concern.

Trap FSM: states T_IDLE, T_REQ, T_WAIT.
- Hit vector: HITS = MON_IN_WINDOW & ARMED.
- T_IDLE: when HITS != 0, capture:
  - TRAP_IDX = lowest set bit of HITS (fixed priority, index 0 highest);
  - TRAP_ADDR = ADDR.
  - Assert TRAP_REQ the next cycle and go to T_REQ.
- T_REQ: TRAP_REQ stays high, and TRAP_IDX/TRAP_ADDR stay stable, until TRAP_ACK=1 is sampled. On that edge TRAP_REQ drops and the FSM goes to T_WAIT.
- T_WAIT: stay until HITS[TRAP_IDX]=0, then go to T_IDLE. A window continuously in range therefore traps once per entry, not every cycle.
- Hits on other windows during T_REQ or T_WAIT are dropped, not queued.
- TRAP_ACK in T_IDLE or T_WAIT has no effect.
- If the trapping window is disarmed or reconfigured during T_REQ, TRAP_REQ stays high until acked (the trap is already committed).
- Asserting RESET_N low mid-operation immediately clears both FSMs, all strobes and ARMED. The monitors keep their contents but are masked.

Test Plan:
- Reset: drive RESET_N=0 mid-sequence (during LD_E) -> all strobes, CFG_BUSY, TRAP_REQ and ARMED read 0 immediately; no further strobes after release.
- Config: CFG_WR with idx 2, start 0x0003, end 0x0006, arm 1 -> MON_LD_START=0100/DATA 0x0003, then MON_LD_END=0100/DATA 0x0006, then MON_ENABLE=0100 on consecutive cycles; ARMED=0100 after COMMIT; a CFG_WR issued while busy produces no strobes.
- Trap: window 2 armed, ADDR counts 0,1,2…; model the monitor hit for 3..6 -> TRAP_REQ rises the cycle after ADDR=3 with TRAP_IDX=2 and TRAP_ADDR=0x0003; hold TRAP_ACK=0 for 5 cycles and confirm the values are stable; ack -> TRAP_REQ falls; no second trap until ADDR leaves and re-enters 3..6.
- Arbitration: windows 1 and 3 both hit in the same cycle -> TRAP_IDX=1; window 3's hit is dropped.
- Disarm: CFG_ARM=0 for window 2 while ADDR is in range -> no strobes issued, ARMED[2]=0, no trap raised; a trap already pending before the disarm stays asserted until TRAP_ACK.

Source files
------------

// File: rtl/window_watch_controller.sv
// Watchpoint window sequencer: loads and enables the address-window monitors, masks their
// hits with per-window arm bits, and turns the highest-priority hit into one req/ack trap.
module window_watch_controller #(
    parameter int NUM_WIN = 4,
    parameter int IDX_W   = 2
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               CFG_WR,
    input  logic [IDX_W-1:0]   CFG_IDX,
    input  logic [15:0]        CFG_START,
    input  logic [15:0]        CFG_END,
    input  logic               CFG_ARM,
    output logic               CFG_BUSY,
    output logic [15:0]        MON_DATA,
    output logic [NUM_WIN-1:0] MON_LD_START,
    output logic [NUM_WIN-1:0] MON_LD_END,
    output logic [NUM_WIN-1:0] MON_ENABLE,
    input  logic [NUM_WIN-1:0] MON_IN_WINDOW,
    input  logic [15:0]        ADDR,
    output logic [NUM_WIN-1:0] ARMED,
    output logic               TRAP_REQ,
    output logic [IDX_W-1:0]   TRAP_IDX,
    output logic [15:0]        TRAP_ADDR,
    input  logic               TRAP_ACK
);

    typedef enum logic [1:0] {IDLE, LD_S, LD_E, COMMIT} cfg_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_WAIT} trap_state_t;

    cfg_state_t          cfg_state_reg;
    trap_state_t         trap_state_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [15:0]         start_reg;
    logic [15:0]         end_reg;
    logic                busy_reg;
    logic [15:0]         data_reg;
    logic [NUM_WIN-1:0]  ld_start_reg;
    logic [NUM_WIN-1:0]  ld_end_reg;
    logic [NUM_WIN-1:0]  enable_reg;
    logic [NUM_WIN-1:0]  armed_reg;
    logic                trap_req_reg;
    logic [IDX_W-1:0]    trap_idx_reg;
    logic [15:0]         trap_addr_reg;

    logic [NUM_WIN-1:0]  idx_onehot;
    logic [NUM_WIN-1:0]  cfg_idx_onehot;
    logic [NUM_WIN-1:0]  trap_onehot;
    logic [NUM_WIN-1:0]  hits;
    logic                cfg_idx_valid;
    logic [IDX_W-1:0]    hit_idx;

    // An out-of-range CFG_IDX decodes to no bit at all, which is what makes it a no-op.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WIN; gi++) begin : g_win
            assign idx_onehot[gi]     = (idx_reg == IDX_W'(gi));
            assign cfg_idx_onehot[gi] = (CFG_IDX == IDX_W'(gi));
            assign trap_onehot[gi]    = (trap_idx_reg == IDX_W'(gi));
            assign hits[gi]           = MON_IN_WINDOW[gi] & armed_reg[gi];
        end
    endgenerate

    assign cfg_idx_valid = |cfg_idx_onehot;

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hits[i]) hit_idx = IDX_W'(i);
        end
    end

    // Strobes are registered one state behind, so ENABLE is presented while the FSM is
    // already back in IDLE; busy_reg marks that trailing cycle, where the arm bit is set.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cfg_state_reg <= IDLE;
            idx_reg       <= '0;
            start_reg     <= '0;
            end_reg       <= '0;
            busy_reg      <= 1'b0;
            data_reg      <= '0;
            ld_start_reg  <= '0;
            ld_end_reg    <= '0;
            enable_reg    <= '0;
            armed_reg     <= '0;
        end else begin
            case (cfg_state_reg)
                IDLE: begin
                    if (busy_reg) begin
                        enable_reg <= '0;
                        data_reg   <= '0;
                        armed_reg  <= armed_reg | idx_onehot;
                        busy_reg   <= 1'b0;
                    end else if (CFG_WR && cfg_idx_valid) begin
                        armed_reg <= armed_reg & ~cfg_idx_onehot;
                        if (CFG_ARM) begin
                            idx_reg       <= CFG_IDX;
                            start_reg     <= CFG_START;
                            end_reg       <= CFG_END;
                            busy_reg      <= 1'b1;
                            cfg_state_reg <= LD_S;
                        end
                    end
                end
                LD_S: begin
                    ld_start_reg  <= idx_onehot;
                    data_reg      <= start_reg;
                    cfg_state_reg <= LD_E;
                end
                LD_E: begin
                    ld_start_reg  <= '0;
                    ld_end_reg    <= idx_onehot;
                    data_reg      <= end_reg;
                    cfg_state_reg <= COMMIT;
                end
                COMMIT: begin
                    ld_end_reg    <= '0;
                    enable_reg    <= idx_onehot;
                    cfg_state_reg <= IDLE;
                end
                default: cfg_state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            trap_state_reg <= T_IDLE;
            trap_req_reg   <= 1'b0;
            trap_idx_reg   <= '0;
            trap_addr_reg  <= '0;
        end else begin
            case (trap_state_reg)
                T_IDLE: begin
                    if (|hits) begin
                        trap_idx_reg   <= hit_idx;
                        trap_addr_reg  <= ADDR;
                        trap_req_reg   <= 1'b1;
                        trap_state_reg <= T_REQ;
                    end
                end
                T_REQ: begin
                    if (TRAP_ACK) begin
                        trap_req_reg   <= 1'b0;
                        trap_state_reg <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    // Re-arm only once the trapping window has been left, so one entry = one trap.
                    if (!(|(hits & trap_onehot))) trap_state_reg <= T_IDLE;
                end
                default: trap_state_reg <= T_IDLE;
            endcase
        end
    end

    assign CFG_BUSY     = busy_reg;
    assign MON_DATA     = data_reg;
    assign MON_LD_START = ld_start_reg;
    assign MON_LD_END   = ld_end_reg;
    assign MON_ENABLE   = enable_reg;
    assign ARMED        = armed_reg;
    assign TRAP_REQ     = trap_req_reg;
    assign TRAP_IDX     = trap_idx_reg;
    assign TRAP_ADDR    = trap_addr_reg;

endmodule

// File: tb/tb_window_watch_controller.sv
// Bench for window_watch_controller: a behavioural model of four window monitors, a
// table of configuration cycles, and directed trap / arbitration / disarm / reset sequences.
module tb_window_watch_controller;

    logic        CLK;
    logic        RESET_N;
    logic        CFG_WR;
    logic [1:0]  CFG_IDX;
    logic [15:0] CFG_START;
    logic [15:0] CFG_END;
    logic        CFG_ARM;
    logic        CFG_BUSY;
    logic [15:0] MON_DATA;
    logic [3:0]  MON_LD_START;
    logic [3:0]  MON_LD_END;
    logic [3:0]  MON_ENABLE;
    logic [3:0]  MON_IN_WINDOW;
    logic [15:0] ADDR;
    logic [3:0]  ARMED;
    logic        TRAP_REQ;
    logic [1:0]  TRAP_IDX;
    logic [15:0] TRAP_ADDR;
    logic        TRAP_ACK;

    int pass_cnt = 0;
    int total_cnt = 0;

    window_watch_controller #(.NUM_WIN(4), .IDX_W(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CFG_WR(CFG_WR), .CFG_IDX(CFG_IDX), .CFG_START(CFG_START), .CFG_END(CFG_END),
        .CFG_ARM(CFG_ARM), .CFG_BUSY(CFG_BUSY),
        .MON_DATA(MON_DATA), .MON_LD_START(MON_LD_START), .MON_LD_END(MON_LD_END),
        .MON_ENABLE(MON_ENABLE), .MON_IN_WINDOW(MON_IN_WINDOW),
        .ADDR(ADDR), .ARMED(ARMED),
        .TRAP_REQ(TRAP_REQ), .TRAP_IDX(TRAP_IDX), .TRAP_ADDR(TRAP_ADDR), .TRAP_ACK(TRAP_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor model: contents survive reset, only the controller's arm mask gates them.
    logic [15:0] m_start [4];
    logic [15:0] m_end   [4];
    logic [3:0]  m_en = 4'b0000;

    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (MON_LD_START[i]) m_start[i] <= MON_DATA;
            if (MON_LD_END[i])   m_end[i]   <= MON_DATA;
            if (MON_ENABLE[i])   m_en[i]    <= 1'b1;
        end
    end

    always_comb begin
        MON_IN_WINDOW = 4'b0000;
        for (int i = 0; i < 4; i++)
            MON_IN_WINDOW[i] = m_en[i] && (ADDR >= m_start[i]) && (ADDR <= m_end[i]);
    end

    typedef struct {
        logic        wr;
        logic [1:0]  idx;
        logic [15:0] cstart;
        logic [15:0] cend;
        logic        arm;
        logic        busy;
        logic [3:0]  lds;
        logic [3:0]  lde;
        logic [3:0]  en;
        logic [15:0] data;
        logic [3:0]  armed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic wr, input logic [1:0] idx, input logic [15:0] s,
                                input logic [15:0] e, input logic arm, input logic busy,
                                input logic [3:0] lds, input logic [3:0] lde, input logic [3:0] en,
                                input logic [15:0] data, input logic [3:0] armed);
        vec_t v;
        v.wr = wr; v.idx = idx; v.cstart = s; v.cend = e; v.arm = arm;
        v.busy = busy; v.lds = lds; v.lde = lde; v.en = en; v.data = data; v.armed = armed;
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_cfg(input string tag, input logic busy, input logic [3:0] lds,
                           input logic [3:0] lde, input logic [3:0] en,
                           input logic [15:0] data, input logic [3:0] armed);
        chk({tag, ".busy"},  32'(CFG_BUSY),     32'(busy));
        chk({tag, ".ldst"},  32'(MON_LD_START), 32'(lds));
        chk({tag, ".ldend"}, 32'(MON_LD_END),   32'(lde));
        chk({tag, ".en"},    32'(MON_ENABLE),   32'(en));
        chk({tag, ".data"},  32'(MON_DATA),     32'(data));
        chk({tag, ".armed"}, 32'(ARMED),        32'(armed));
    endtask

    task automatic chk_trap(input string tag, input logic req, input logic [1:0] idx,
                            input logic [15:0] addr);
        chk({tag, ".req"}, 32'(TRAP_REQ), 32'(req));
        if (req) begin
            chk({tag, ".idx"},  32'(TRAP_IDX),  32'(idx));
            chk({tag, ".addr"}, 32'(TRAP_ADDR), 32'(addr));
        end
        $display("%s: addr=0x%04h req=%0d idx=%0d taddr=0x%04h", tag, ADDR, TRAP_REQ, TRAP_IDX, TRAP_ADDR);
    endtask

    task automatic set_addr(input logic [15:0] a, input logic ack);
        ADDR = a;
        TRAP_ACK = ack;
    endtask

    initial begin
        RESET_N = 1'b0; CFG_WR = 1'b0; CFG_IDX = '0; CFG_START = '0; CFG_END = '0;
        CFG_ARM = 1'b0; ADDR = '0; TRAP_ACK = 1'b0;

        // Window 2 = 3..6 (plus an ignored write while busy), window 1 = 0x20..0x2F,
        // window 3 = 0x28..0x30, then window 2 again to see its arm bit drop on entry.
        vecs.push_back(mk(1, 2, 16'h0003, 16'h0006, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0));
        vecs.push_back(mk(1, 0, 16'h0010, 16'h0020, 1, 1, 4'h4, 4'h0, 4'h0, 16'h0003, 4'h0));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h4, 4'h0, 16'h0006, 4'h0));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h0, 4'h4, 16'h0006, 4'h0));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h4));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h4));
        vecs.push_back(mk(1, 1, 16'h0020, 16'h002F, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h4));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h2, 4'h0, 4'h0, 16'h0020, 4'h4));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h2, 4'h0, 16'h002F, 4'h4));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h0, 4'h2, 16'h002F, 4'h4));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h6));
        vecs.push_back(mk(1, 3, 16'h0028, 16'h0030, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h6));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h8, 4'h0, 4'h0, 16'h0028, 4'h6));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h8, 4'h0, 16'h0030, 4'h6));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h0, 4'h8, 16'h0030, 4'h6));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'hE));
        vecs.push_back(mk(1, 2, 16'h0003, 16'h0006, 1, 1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'hA));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h4, 4'h0, 4'h0, 16'h0003, 4'hA));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h4, 4'h0, 16'h0006, 4'hA));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 4'h0, 4'h0, 4'h4, 16'h0006, 4'hA));
        vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'hE));

        step(); step();
        chk_cfg("reset", 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0);
        chk_trap("reset", 0, 2'd0, 16'h0000);
        RESET_N = 1'b1;
        step();

        for (int r = 0; r < vecs.size(); r++) begin
            CFG_WR = vecs[r].wr; CFG_IDX = vecs[r].idx; CFG_START = vecs[r].cstart;
            CFG_END = vecs[r].cend; CFG_ARM = vecs[r].arm;
            step();
            chk_cfg($sformatf("cfg[%0d]", r), vecs[r].busy, vecs[r].lds, vecs[r].lde,
                    vecs[r].en, vecs[r].data, vecs[r].armed);
            chk($sformatf("cfg[%0d].req", r), 32'(TRAP_REQ), 32'd0);
            $display("cfg[%0d]: busy=%0d lds=%b lde=%b en=%b data=0x%04h armed=%b", r,
                     CFG_BUSY, MON_LD_START, MON_LD_END, MON_ENABLE, MON_DATA, ARMED);
        end
        CFG_WR = 1'b0; CFG_ARM = 1'b0;

        // Counting address stream through window 2 (3..6).
        for (int a = 0; a < 3; a++) begin
            set_addr(16'(a), 0); step(); chk_trap("count", 0, 2'd0, 16'h0000);
        end
        set_addr(16'h0003, 0); step(); chk_trap("enter", 1, 2'd2, 16'h0003);
        set_addr(16'h0004, 0); step(); chk_trap("hold1", 1, 2'd2, 16'h0003);
        set_addr(16'h0005, 0); step(); chk_trap("hold2", 1, 2'd2, 16'h0003);
        set_addr(16'h0006, 0); step(); chk_trap("hold3", 1, 2'd2, 16'h0003);
        set_addr(16'h0006, 0); step(); chk_trap("hold4", 1, 2'd2, 16'h0003);
        set_addr(16'h0006, 0); step(); chk_trap("hold5", 1, 2'd2, 16'h0003);
        set_addr(16'h0006, 1); step(); chk_trap("ack", 0, 2'd0, 16'h0000);
        set_addr(16'h0005, 0); step(); chk_trap("inwin1", 0, 2'd0, 16'h0000);
        set_addr(16'h0004, 0); step(); chk_trap("inwin2", 0, 2'd0, 16'h0000);
        set_addr(16'h0007, 0); step(); chk_trap("leave", 0, 2'd0, 16'h0000);
        set_addr(16'h0008, 0); step(); chk_trap("out", 0, 2'd0, 16'h0000);
        set_addr(16'h0004, 0); step(); chk_trap("reenter", 1, 2'd2, 16'h0004);
        set_addr(16'h000A, 1); step(); chk_trap("ack2", 0, 2'd0, 16'h0000);
        set_addr(16'h000B, 0); step(); chk_trap("idle", 0, 2'd0, 16'h0000);

        // 0x2A lies in windows 1 and 3; the lower index wins, the other hit is lost.
        set_addr(16'h002A, 0); step(); chk_trap("arb", 1, 2'd1, 16'h002A);
        set_addr(16'h0000, 1); step(); chk_trap("arb_ack", 0, 2'd0, 16'h0000);
        set_addr(16'h0000, 0); step(); chk_trap("arb_drop1", 0, 2'd0, 16'h0000);
        step(); chk_trap("arb_drop2", 0, 2'd0, 16'h0000);

        // Disarm window 2 while its trap is pending and the address stays in range.
        set_addr(16'h0005, 0); step(); chk_trap("pend", 1, 2'd2, 16'h0005);
        CFG_WR = 1'b1; CFG_IDX = 2'd2; CFG_ARM = 1'b0;
        step();
        CFG_WR = 1'b0;
        chk_cfg("disarm", 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'hA);
        chk_trap("disarm", 1, 2'd2, 16'h0005);
        step();
        chk_cfg("disarm2", 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'hA);
        chk_trap("disarm2", 1, 2'd2, 16'h0005);
        set_addr(16'h0005, 1); step(); chk_trap("dis_ack", 0, 2'd0, 16'h0000);
        set_addr(16'h0005, 0); step(); chk_trap("dis_idle1", 0, 2'd0, 16'h0000);
        step(); chk_trap("dis_idle2", 0, 2'd0, 16'h0000);

        // Reset during the LD_END cycle with a trap pending on window 1.
        CFG_WR = 1'b1; CFG_IDX = 2'd0; CFG_START = 16'h0040; CFG_END = 16'h0050; CFG_ARM = 1'b1;
        set_addr(16'h002A, 0);
        step();
        CFG_WR = 1'b0; CFG_ARM = 1'b0;
        chk_cfg("rcfg0", 1, 4'h0, 4'h0, 4'h0, 16'h0000, 4'hA);
        chk_trap("rcfg0", 1, 2'd1, 16'h002A);
        step();
        chk_cfg("rcfg1", 1, 4'h1, 4'h0, 4'h0, 16'h0040, 4'hA);
        step();
        chk_cfg("rcfg2", 1, 4'h0, 4'h1, 4'h0, 16'h0050, 4'hA);
        #2 RESET_N = 1'b0;
        #1;
        chk_cfg("async_rst", 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0);
        chk_trap("async_rst", 0, 2'd0, 16'h0000);
        step();
        RESET_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_cfg($sformatf("post_rst[%0d]", k), 0, 4'h0, 4'h0, 4'h0, 16'h0000, 4'h0);
            chk_trap($sformatf("post_rst[%0d]", k), 0, 2'd0, 16'h0000);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
